// File: rtl/io_ctrl_pkg.sv
// Shared types and IO register indices for the core's memory-mapped IO window.
package io_ctrl_pkg;

  typedef logic [15:0] DataAddrPath;
  typedef logic [31:0] DataPath;
  typedef logic [31:0] CyclePath;
  typedef logic [7:0]  LampPath;
  typedef logic [6:0]  IoIdx;

  localparam IoIdx IO_ADDR_FINISH     = 7'h00;
  localparam IoIdx IO_ADDR_SORT_COUNT = 7'h01;
  localparam IoIdx IO_ADDR_LAMP       = 7'h02;
  localparam IoIdx IO_ADDR_START      = 7'h03;
  localparam IoIdx IO_ADDR_BTN_BASE   = 7'h04;
  localparam IoIdx IO_ADDR_CYCLE      = 7'h07;
  localparam IoIdx IO_ADDR_DISP_BEGIN = 7'h08;
  localparam IoIdx IO_ADDR_LED_CTRL   = 7'h7F;

  function automatic logic io_hit(input DataAddrPath addr);
    return addr[15];
  endfunction

  function automatic IoIdx io_idx(input DataAddrPath addr);
    return addr[8:2];
  endfunction

endpackage

// File: rtl/io_ctrl_btn_debounce.sv
// One push-button: 2-FF synchroniser, stability counter and accepted level with rising pulse.
module io_ctrl_btn_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 50000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_i,
  output logic level_o,
  output logic rise_o
);

  localparam int unsigned CntW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CntW-1:0] CntMax = CntW'(DEBOUNCE_CYCLES - 1);
  localparam logic [CntW-1:0] CntOne = CntW'(1);

  logic            sync1_q, sync2_q;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            level_q, level_d;

  // Counter only advances while the synced input disagrees with the accepted level.
  always_comb begin
    cnt_d   = '0;
    level_d = level_q;
    rise_o  = 1'b0;
    if (sync2_q != level_q) begin
      if (cnt_q == CntMax) begin
        level_d = sync2_q;
        rise_o  = sync2_q;
      end else begin
        cnt_d = cnt_q + CntOne;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      cnt_q   <= '0;
      level_q <= 1'b0;
    end else begin
      sync1_q <= btn_i;
      sync2_q <= sync1_q;
      cnt_q   <= cnt_d;
      level_q <= level_d;
    end
  end

  assign level_o = level_q;

endmodule

// File: rtl/io_ctrl.sv
// Memory-mapped IO controller: sort timing, lamp/LED control, debounced buttons,
// free-running cycle counter and display buffer.
module io_ctrl
  import io_ctrl_pkg::*;
#(
  parameter int unsigned NUM_BTN         = 3,
  parameter int unsigned NUM_DISP_WORDS  = 32,
  parameter int unsigned CYCLE_WIDTH     = 32,
  parameter int unsigned LAMP_WIDTH      = 8,
  parameter int unsigned DEBOUNCE_CYCLES = 50000
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [15:0]                  addr_i,
  input  logic                         wr_en_i,
  input  logic [31:0]                  wr_data_i,
  input  logic                         rd_en_i,
  output logic [31:0]                  rd_data_o,
  input  logic [NUM_BTN-1:0]           btn_i,
  output logic [LAMP_WIDTH-1:0]        lamp_o,
  output logic                         led_ctrl_o,
  output logic [CYCLE_WIDTH-1:0]       sort_cycle_o,
  output logic [31:0]                  sort_count_o,
  output logic                         sort_done_o,
  output logic [NUM_DISP_WORDS*32-1:0] disp_data_o
);

  localparam logic [CYCLE_WIDTH-1:0] CycOne = CYCLE_WIDTH'(1);

  logic hit, wr, rd;
  IoIdx idx;
  logic unused_addr;

  assign hit         = io_hit(addr_i);
  assign idx         = io_idx(addr_i);
  assign wr          = wr_en_i & hit;
  assign rd          = rd_en_i & hit;
  assign unused_addr = ^{addr_i[14:9], addr_i[1:0]};

  logic                                 running_q, running_d;
  logic                                 done_q, done_d;
  logic [CYCLE_WIDTH-1:0]               sort_cycle_q, sort_cycle_d;
  logic [CYCLE_WIDTH-1:0]               free_q;
  DataPath                              sort_count_q, sort_count_d;
  logic [LAMP_WIDTH-1:0]                lamp_q, lamp_d;
  logic                                 led_q, led_d;
  logic [NUM_DISP_WORDS-1:0][31:0]      disp_q, disp_d;
  logic [NUM_BTN-1:0]                   sticky_q, sticky_d;
  logic [NUM_BTN-1:0]                   level, rise;

  for (genvar g = 0; g < NUM_BTN; g++) begin : g_btn
    io_ctrl_btn_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debounce (
      .clk    (clk),
      .rst_n  (rst_n),
      .btn_i  (btn_i[g]),
      .level_o(level[g]),
      .rise_o (rise[g])
    );
  end

  always_comb begin
    running_d    = running_q;
    done_d       = done_q;
    sort_cycle_d = sort_cycle_q;
    sort_count_d = sort_count_q;
    lamp_d       = lamp_q;
    led_d        = led_q;
    disp_d       = disp_q;
    sticky_d     = sticky_q;

    // The FINISH cycle itself still counts, so START..FINISH spans give the gap.
    if (running_q && (sort_cycle_q != '1)) sort_cycle_d = sort_cycle_q + CycOne;

    if (wr) begin
      if (idx == IO_ADDR_FINISH && running_q) begin
        running_d = 1'b0;
        done_d    = 1'b1;
      end
      if (idx == IO_ADDR_START) begin
        running_d    = 1'b1;
        done_d       = 1'b0;
        sort_cycle_d = '0;
      end
      if (idx == IO_ADDR_SORT_COUNT) sort_count_d = wr_data_i;
      if (idx == IO_ADDR_LAMP)       lamp_d       = wr_data_i[LAMP_WIDTH-1:0];
      if (idx == IO_ADDR_LED_CTRL)   led_d        = wr_data_i[0];
      for (int unsigned k = 0; k < NUM_DISP_WORDS; k++) begin
        if (idx == IoIdx'(IO_ADDR_DISP_BEGIN + k)) disp_d[k] = wr_data_i;
      end
    end

    // A rise on the same edge as a clearing read keeps the flag set.
    for (int unsigned i = 0; i < NUM_BTN; i++) begin
      if (rd && idx == IoIdx'(IO_ADDR_BTN_BASE + i)) sticky_d[i] = 1'b0;
      if (rise[i]) sticky_d[i] = 1'b1;
    end
  end

  always_comb begin
    rd_data_o = '0;
    if (hit) begin
      case (idx)
        IO_ADDR_FINISH:     rd_data_o = {31'b0, done_q};
        IO_ADDR_SORT_COUNT: rd_data_o = sort_count_q;
        IO_ADDR_LAMP:       rd_data_o = DataPath'(lamp_q);
        IO_ADDR_START:      rd_data_o = {31'b0, running_q};
        IO_ADDR_CYCLE:      rd_data_o = DataPath'(free_q);
        IO_ADDR_LED_CTRL:   rd_data_o = {31'b0, led_q};
        default: begin
          for (int unsigned i = 0; i < NUM_BTN; i++) begin
            if (idx == IoIdx'(IO_ADDR_BTN_BASE + i)) rd_data_o = {30'b0, sticky_q[i], level[i]};
          end
          for (int unsigned k = 0; k < NUM_DISP_WORDS; k++) begin
            if (idx == IoIdx'(IO_ADDR_DISP_BEGIN + k)) rd_data_o = disp_q[k];
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      running_q    <= 1'b0;
      done_q       <= 1'b0;
      sort_cycle_q <= '0;
      free_q       <= '0;
      sort_count_q <= '0;
      lamp_q       <= '0;
      led_q        <= 1'b0;
      disp_q       <= '0;
      sticky_q     <= '0;
    end else begin
      running_q    <= running_d;
      done_q       <= done_d;
      sort_cycle_q <= sort_cycle_d;
      free_q       <= free_q + CycOne;
      sort_count_q <= sort_count_d;
      lamp_q       <= lamp_d;
      led_q        <= led_d;
      disp_q       <= disp_d;
      sticky_q     <= sticky_d;
    end
  end

  assign lamp_o       = lamp_q;
  assign led_ctrl_o   = led_q;
  assign sort_cycle_o = sort_cycle_q;
  assign sort_count_o = sort_count_q;
  assign sort_done_o  = done_q;
  assign disp_data_o  = disp_q;

endmodule

// File: tb/tb_io_ctrl.sv
// Self-checking bench for io_ctrl with randomized register traffic against a behavioural model.
module tb_io_ctrl;

  localparam int unsigned NB = 3;
  localparam int unsigned ND = 32;
  localparam int unsigned CW = 32;
  localparam int unsigned LW = 8;
  localparam int unsigned DB = 4;

  logic             clk;
  logic             rst_n;
  logic [15:0]      addr;
  logic             wr_en;
  logic [31:0]      wr_data;
  logic             rd_en;
  logic [31:0]      rd_data;
  logic [NB-1:0]    btn;
  logic [LW-1:0]    lamp;
  logic             led_ctrl;
  logic [CW-1:0]    sort_cycle;
  logic [31:0]      sort_count;
  logic             sort_done;
  logic [ND*32-1:0] disp_data;

  io_ctrl #(
    .NUM_BTN        (NB),
    .NUM_DISP_WORDS (ND),
    .CYCLE_WIDTH    (CW),
    .LAMP_WIDTH     (LW),
    .DEBOUNCE_CYCLES(DB)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .addr_i      (addr),
    .wr_en_i     (wr_en),
    .wr_data_i   (wr_data),
    .rd_en_i     (rd_en),
    .rd_data_o   (rd_data),
    .btn_i       (btn),
    .lamp_o      (lamp),
    .led_ctrl_o  (led_ctrl),
    .sort_cycle_o(sort_cycle),
    .sort_count_o(sort_count),
    .sort_done_o (sort_done),
    .disp_data_o (disp_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Behavioural model of the plain storage registers
  logic [31:0] m_disp [ND];
  logic [31:0] m_sort_count;
  logic [7:0]  m_lamp;
  logic        m_led;

  function automatic logic [15:0] io(input int unsigned idx);
    return 16'h8000 | 16'(idx << 2);
  endfunction

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wr(input logic [15:0] a, input logic [31:0] d);
    addr = a; wr_data = d; wr_en = 1'b1;
    tick();
    wr_en = 1'b0;
  endtask

  task automatic rd(input logic [15:0] a, output logic [31:0] d);
    addr = a; rd_en = 1'b1;
    #1;
    d = rd_data;
    tick();
    rd_en = 1'b0;
  endtask

  task automatic model_clear();
    for (int k = 0; k < ND; k++) m_disp[k] = '0;
    m_sort_count = '0; m_lamp = '0; m_led = 1'b0;
  endtask

  task automatic test_reset();
    logic [31:0] d;
    int idxs [3] = '{2, 0, 8};
    rst_n = 1'b0; addr = '0; wr_en = 0; wr_data = '0; rd_en = 0; btn = '0;
    model_clear();
    #23 rst_n = 1'b1;
    tick();
    foreach (idxs[i]) begin
      rd(io(idxs[i]), d);
      n_checks++;
      if (d !== 32'h0) begin
        n_fail++; $display("FAIL reset_read idx=%0h got=%h exp=0", idxs[i], d);
      end
    end
    n_checks++;
    if (lamp !== '0 || led_ctrl !== 1'b0 || sort_done !== 1'b0 || sort_cycle !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs lamp=%h led=%b done=%b cyc=%0d exp all 0",
               lamp, led_ctrl, sort_done, sort_cycle);
    end
  endtask

  task automatic run_sort(input int gap);
    logic [31:0] d;
    wr(io(3), '0);
    tick(gap - 1);
    wr(io(0), '0);
    n_checks++;
    if (sort_done !== 1'b1 || sort_cycle !== CW'(gap)) begin
      n_fail++;
      $display("FAIL sort_gap done=%b cyc=%0d exp done=1 cyc=%0d", sort_done, sort_cycle, gap);
    end
    rd(io(3), d);
    n_checks++;
    if (d !== 32'h0) begin n_fail++; $display("FAIL running_after_finish got=%h exp=0", d); end
    rd(io(0), d);
    n_checks++;
    if (d !== 32'h1) begin n_fail++; $display("FAIL finish_read got=%h exp=1", d); end
    tick(50);
    wr(io(0), '0);
    n_checks++;
    if (sort_cycle !== CW'(gap) || sort_done !== 1'b1) begin
      n_fail++;
      $display("FAIL sort_hold cyc=%0d done=%b exp cyc=%0d done=1", sort_cycle, sort_done, gap);
    end
  endtask

  task automatic test_sort();
    run_sort(100);
    run_sort(int'($urandom_range(2, 300)));
  endtask

  task automatic test_restart();
    wr(io(3), '0);
    tick(20);
    wr(io(3), '0);
    n_checks++;
    if (sort_done !== 1'b0 || sort_cycle !== '0) begin
      n_fail++; $display("FAIL restart_clear done=%b cyc=%0d exp 0/0", sort_done, sort_cycle);
    end
    tick(9);
    wr(io(0), '0);
    n_checks++;
    if (sort_cycle !== CW'(10)) begin
      n_fail++; $display("FAIL restart_gap cyc=%0d exp=10", sort_cycle);
    end
  endtask

  task automatic test_buttons();
    logic [31:0] d;
    int sel;
    btn = 3'b010; tick(3); btn = '0; tick(10);
    rd(io(5), d);
    n_checks++;
    if (d !== 32'h0) begin n_fail++; $display("FAIL btn_glitch got=%h exp=0", d); end
    btn = 3'b010; tick(10);
    rd(io(5), d);
    n_checks++;
    if (d !== 32'h3) begin n_fail++; $display("FAIL btn_press got=%h exp=3", d); end
    rd(io(5), d);
    n_checks++;
    if (d !== 32'h1) begin n_fail++; $display("FAIL btn_sticky_clr got=%h exp=1", d); end
    btn = '0; tick(10);
    rd(io(5), d);
    n_checks++;
    if (d !== 32'h0) begin n_fail++; $display("FAIL btn_release got=%h exp=0", d); end

    // Accepted after 2 sync edges plus DB mismatched edges; the read lands on the accepting edge.
    sel = int'($urandom_range(0, NB - 1));
    btn[sel] = 1'b1;
    tick(DB + 1);
    rd(io(4 + sel), d);
    n_checks++;
    if (d !== 32'h0) begin n_fail++; $display("FAIL btn_pre_edge b=%0d got=%h exp=0", sel, d); end
    rd(io(4 + sel), d);
    n_checks++;
    if (d !== 32'h3) begin n_fail++; $display("FAIL btn_set_wins b=%0d got=%h exp=3", sel, d); end
    for (int j = 0; j < NB; j++) begin
      if (j != sel) begin
        rd(io(4 + j), d);
        n_checks++;
        if (d !== 32'h0) begin n_fail++; $display("FAIL btn_other b=%0d got=%h exp=0", j, d); end
      end
    end
    btn = '0; tick(10);
  endtask

  task automatic test_regs();
    logic [31:0] d, exp, dat;
    logic [15:0] a;
    int kind, w;
    bit nonio;
    wr(16'h8020, 32'hDEADBEEF); m_disp[0] = 32'hDEADBEEF;
    wr(16'h8008, 32'h000000A5); m_lamp = 8'hA5;
    wr(16'h0008, 32'h0000005A);
    n_checks++;
    if (disp_data[31:0] !== 32'hDEADBEEF || lamp !== 8'hA5) begin
      n_fail++; $display("FAIL directed_wr disp0=%h lamp=%h exp DEADBEEF/A5", disp_data[31:0], lamp);
    end
    wr(io(7'h50), $urandom);
    rd(io(7'h50), d);
    n_checks++;
    if (d !== 32'h0) begin n_fail++; $display("FAIL unmapped_read got=%h exp=0", d); end

    for (int it = 0; it < 60; it++) begin
      kind = int'($urandom_range(0, 3));
      w = int'($urandom_range(0, ND - 1));
      dat = $urandom;
      nonio = ($urandom_range(0, 4) == 0);
      case (kind)
        0:       a = io(2);
        1:       a = io(1);
        2:       a = io(8 + w);
        default: a = io(7'h7F);
      endcase
      if (nonio) a[15] = 1'b0;
      wr(a, dat);
      if (!nonio) begin
        case (kind)
          0:       m_lamp = dat[7:0];
          1:       m_sort_count = dat;
          2:       m_disp[w] = dat;
          default: m_led = dat[0];
        endcase
      end
      a[15] = 1'b1;
      case (kind)
        0:       exp = {24'b0, m_lamp};
        1:       exp = m_sort_count;
        2:       exp = m_disp[w];
        default: exp = {31'b0, m_led};
      endcase
      rd(a, d);
      n_checks++;
      if (d !== exp) begin
        n_fail++; $display("FAIL reg_rw it=%0d kind=%0d got=%h exp=%h", it, kind, d, exp);
      end
    end
    n_checks++;
    if (lamp !== m_lamp || led_ctrl !== m_led || sort_count !== m_sort_count) begin
      n_fail++;
      $display("FAIL reg_outputs lamp=%h led=%b cnt=%h exp %h/%b/%h",
               lamp, led_ctrl, sort_count, m_lamp, m_led, m_sort_count);
    end
    for (int k = 0; k < ND; k++) begin
      n_checks++;
      if (disp_data[32*k +: 32] !== m_disp[k]) begin
        n_fail++; $display("FAIL disp_word k=%0d got=%h exp=%h", k, disp_data[32*k +: 32], m_disp[k]);
      end
    end
  endtask

  task automatic test_simul_rw();
    logic [31:0] d, nv;
    nv = $urandom;
    addr = io(1); wr_data = nv; wr_en = 1'b1; rd_en = 1'b1;
    #1 d = rd_data;
    tick();
    wr_en = 1'b0; rd_en = 1'b0;
    n_checks++;
    if (d !== m_sort_count) begin n_fail++; $display("FAIL rw_old got=%h exp=%h", d, m_sort_count); end
    m_sort_count = nv;
    n_checks++;
    if (sort_count !== nv) begin n_fail++; $display("FAIL rw_new got=%h exp=%h", sort_count, nv); end
  endtask

  task automatic test_cycle();
    logic [31:0] c1, c2;
    int k;
    k = int'($urandom_range(1, 100));
    rd(io(7), c1);
    tick(k);
    rd(io(7), c2);
    n_checks++;
    if (c2 - c1 !== 32'(k + 1)) begin
      n_fail++; $display("FAIL cycle_delta got=%0d exp=%0d", c2 - c1, k + 1);
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] d;
    wr(io(2), 32'h3C); m_lamp = 8'h3C;
    wr(io(3), '0);
    tick(37);
    n_checks++;
    if (sort_cycle !== CW'(37)) begin n_fail++; $display("FAIL pre_reset_cyc got=%0d exp=37", sort_cycle); end
    addr = io(2);
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if (sort_cycle !== '0 || sort_done !== 1'b0 || lamp !== '0 || led_ctrl !== 1'b0 ||
        disp_data !== '0 || rd_data !== 32'h0) begin
      n_fail++;
      $display("FAIL async_reset cyc=%0d done=%b lamp=%h led=%b rd=%h exp all 0",
               sort_cycle, sort_done, lamp, led_ctrl, rd_data);
    end
    model_clear();
    #10 rst_n = 1'b1;
    tick();
    rd(io(3), d);
    n_checks++;
    if (d !== 32'h0) begin n_fail++; $display("FAIL reset_abort_running got=%h exp=0", d); end
  endtask

  initial begin
    test_reset();
    test_sort();
    test_restart();
    test_buttons();
    test_regs();
    test_simul_rw();
    test_cycle();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
